// File: rtl/muladd_row_sched.sv
// muladd_row_sched
// Row scheduler sitting in front of the MulAdd processing element.
// Incoming load words are packed into ROW_LEN-word rows inside a two-bank
// ping-pong buffer. Complete rows are offered to the PE over a valid/ready
// handshake together with their index inside the frame and first/last flags.
// Result strobes coming back from the PE are counted; once a whole frame of
// ROWS rows has been answered a one-cycle frame_done_o pulse is produced.
//
// Ports:
//   clk_data        sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   load_en_i       load word valid this cycle
//   load_payload_i  load word
//   pe_row_valid_o  row offered to PE
//   pe_row_ready_i  PE accepts the offered row
//   pe_row_data_o   row data, lane 0 = first word received
//   pe_row_idx_o    row index within the frame
//   pe_first_o      offered row is index 0
//   pe_last_o       offered row is index ROWS-1
//   result_valid_i  PE result strobe, one per row
//   busy_o          FSM not idle or any bank holding a full row
//   frame_done_o    one-cycle pulse when a frame is complete
//   overflow_o      sticky: a load word was dropped
//   proto_err_o     sticky: unexpected result strobe
//   clr_err_i       clears both sticky flags
module muladd_row_sched #(
   parameter  int DATA_W  = 32,
   parameter  int ROW_LEN = 8,
   parameter  int ROWS    = 8,
   localparam int IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int WC_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1,
   localparam int RC_W    = $clog2(ROWS + 1)
) (
   input  logic                      clk_data,
   input  logic                      rst_n,
   input  logic                      load_en_i,
   input  logic [DATA_W-1:0]         load_payload_i,
   output logic                      pe_row_valid_o,
   input  logic                      pe_row_ready_i,
   output logic [ROW_LEN*DATA_W-1:0] pe_row_data_o,
   output logic [IDX_W-1:0]          pe_row_idx_o,
   output logic                      pe_first_o,
   output logic                      pe_last_o,
   input  logic                      result_valid_i,
   output logic                      busy_o,
   output logic                      frame_done_o,
   output logic                      overflow_o,
   output logic                      proto_err_o,
   input  logic                      clr_err_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                    state;
   logic [ROW_LEN*DATA_W-1:0] bank_data [2];
   logic [1:0]                bank_full;
   logic [WC_W-1:0]           word_cnt;
   logic                      wr_bank;
   logic                      rd_bank;
   logic [IDX_W-1:0]          row_idx;
   logic [RC_W-1:0]           result_cnt;

   logic                      handshake;
   logic                      word_accept;
   logic                      word_drop;
   logic [RC_W-1:0]           issued_cnt;
   logic                      strobe_ok;
   logic                      strobe_bad;

   // Rows held while draining stay invisible to the PE so that a new frame
   // cannot start before the previous one has been fully answered.
   assign pe_row_valid_o = bank_full[rd_bank] && (state != DRAIN);
   assign pe_row_data_o  = bank_data[rd_bank];
   assign pe_row_idx_o   = row_idx;
   assign pe_first_o     = pe_row_valid_o && (row_idx == '0);
   assign pe_last_o      = pe_row_valid_o && (row_idx == IDX_W'(ROWS - 1));
   assign busy_o         = (state != IDLE) || (|bank_full);

   assign handshake   = pe_row_valid_o && pe_row_ready_i;
   assign word_accept = load_en_i && !bank_full[wr_bank];
   assign word_drop   = load_en_i && bank_full[wr_bank];

   // Rows issued so far in this frame: row_idx counts them while running,
   // and once the last row has gone out it has wrapped back to zero, so the
   // drain state stands for a full frame.
   always_comb begin
      issued_cnt = RC_W'(row_idx);
      if (state == DRAIN) begin
         issued_cnt = RC_W'(ROWS);
      end
   end

   assign strobe_ok  = result_valid_i && (state != IDLE) && (result_cnt < issued_cnt);
   assign strobe_bad = result_valid_i && !strobe_ok;

   // Write side: pack words into the current bank and flip banks on a full row.
   // Read side: free the bank and advance the row index on each handshake.
   // A bank can never be set and cleared in the same cycle because setting
   // requires it to be empty and clearing requires it to be full.
   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         bank_data[0] <= '0;
         bank_data[1] <= '0;
         bank_full    <= '0;
         word_cnt     <= '0;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         row_idx      <= '0;
      end else begin
         if (word_accept) begin
            bank_data[wr_bank][word_cnt*DATA_W +: DATA_W] <= load_payload_i;
            if (word_cnt == WC_W'(ROW_LEN - 1)) begin
               bank_full[wr_bank] <= 1'b1;
               word_cnt           <= '0;
               wr_bank            <= ~wr_bank;
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
         end
         if (handshake) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
            if (row_idx == IDX_W'(ROWS - 1)) begin
               row_idx <= '0;
            end else begin
               row_idx <= row_idx + 1'b1;
            end
         end
      end
   end

   // Frame FSM and result counting. The frame closes on the strobe that
   // brings result_cnt to ROWS, so the done pulse and the return to IDLE
   // happen on the same edge as that strobe.
   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         result_cnt   <= '0;
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (handshake) begin
                  state <= (ROWS == 1) ? DRAIN : RUN;
               end
            end
            RUN: begin
               if (handshake && (row_idx == IDX_W'(ROWS - 1))) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (strobe_ok && (result_cnt == RC_W'(ROWS - 1))) begin
                  state        <= IDLE;
                  frame_done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (strobe_ok) begin
            if ((state == DRAIN) && (result_cnt == RC_W'(ROWS - 1))) begin
               result_cnt <= '0;
            end else begin
               result_cnt <= result_cnt + 1'b1;
            end
         end
      end
   end

   // Sticky error flags: a clear is applied first so that a set event in the
   // same cycle takes priority.
   always_ff @(posedge clk_data or negedge rst_n) begin
      if (!rst_n) begin
         overflow_o  <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         if (clr_err_i) begin
            overflow_o  <= 1'b0;
            proto_err_o <= 1'b0;
         end
         if (word_drop) begin
            overflow_o <= 1'b1;
         end
         if (strobe_bad) begin
            proto_err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_muladd_row_sched.sv
// tb_muladd_row_sched
// Directed, self-checking bench for muladd_row_sched. A table of per-cycle
// records covers a full frame; hand-written sequences cover overflow, load
// gaps, rows held during drain, protocol errors and mid-frame reset.
module tb_muladd_row_sched;

   localparam int DATA_W  = 32;
   localparam int ROW_LEN = 8;
   localparam int ROWS    = 8;

   logic                      clk_data = 1'b0;
   logic                      rst_n = 1'b1;
   logic                      load_en_i = 1'b0;
   logic [DATA_W-1:0]         load_payload_i = '0;
   logic                      pe_row_valid_o;
   logic                      pe_row_ready_i = 1'b0;
   logic [ROW_LEN*DATA_W-1:0] pe_row_data_o;
   logic [2:0]                pe_row_idx_o;
   logic                      pe_first_o;
   logic                      pe_last_o;
   logic                      result_valid_i = 1'b0;
   logic                      busy_o;
   logic                      frame_done_o;
   logic                      overflow_o;
   logic                      proto_err_o;
   logic                      clr_err_i = 1'b0;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic        load_en;
      logic [31:0] payload;
      logic        ready;
      logic        res;
      logic        clr;
      logic        exp_valid;
      logic [2:0]  exp_idx;
      logic        exp_first;
      logic        exp_last;
      logic [31:0] exp_lane0;
      logic        exp_busy;
      logic        exp_done;
      logic        exp_ovf;
      logic        exp_perr;
   } vec_t;

   vec_t vecs[$];

   muladd_row_sched #(
      .DATA_W (DATA_W),
      .ROW_LEN(ROW_LEN),
      .ROWS   (ROWS)
   ) dut (
      .clk_data      (clk_data),
      .rst_n         (rst_n),
      .load_en_i     (load_en_i),
      .load_payload_i(load_payload_i),
      .pe_row_valid_o(pe_row_valid_o),
      .pe_row_ready_i(pe_row_ready_i),
      .pe_row_data_o (pe_row_data_o),
      .pe_row_idx_o  (pe_row_idx_o),
      .pe_first_o    (pe_first_o),
      .pe_last_o     (pe_last_o),
      .result_valid_i(result_valid_i),
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o),
      .overflow_o    (overflow_o),
      .proto_err_o   (proto_err_o),
      .clr_err_i     (clr_err_i)
   );

   // Free-running clock.
   always #5 clk_data = ~clk_data;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lane(input int k);
      return pe_row_data_o[k*DATA_W +: DATA_W];
   endfunction

   task automatic checkRow(input string name, input logic [31:0] base);
      for (int j = 0; j < ROW_LEN; j++) begin
         checkOutput($sformatf("%s lane%0d", name, j), lane(j), base + 32'(j));
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_data);
      #1;
   endtask

   task automatic sendWord(input logic [31:0] w);
      load_en_i      = 1'b1;
      load_payload_i = w;
      tick();
      load_en_i = 1'b0;
   endtask

   task automatic checkZeros(input string tag);
      checkOutput({tag, " valid"}, 32'(pe_row_valid_o), 0);
      checkOutput({tag, " data"}, 32'(|pe_row_data_o), 0);
      checkOutput({tag, " idx"}, 32'(pe_row_idx_o), 0);
      checkOutput({tag, " first"}, 32'(pe_first_o), 0);
      checkOutput({tag, " last"}, 32'(pe_last_o), 0);
      checkOutput({tag, " busy"}, 32'(busy_o), 0);
      checkOutput({tag, " done"}, 32'(frame_done_o), 0);
      checkOutput({tag, " ovf"}, 32'(overflow_o), 0);
      checkOutput({tag, " perr"}, 32'(proto_err_o), 0);
   endtask

   task automatic doReset(input string tag);
      load_en_i      = 1'b0;
      pe_row_ready_i = 1'b0;
      result_valid_i = 1'b0;
      clr_err_i      = 1'b0;
      rst_n          = 1'b0;
      #1;
      checkZeros(tag);
      repeat (2) @(posedge clk_data);
      @(negedge clk_data);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic applyStimulus(input vec_t v);
      load_en_i      = v.load_en;
      load_payload_i = v.payload;
      pe_row_ready_i = v.ready;
      result_valid_i = v.res;
      clr_err_i      = v.clr;
      tick();
   endtask

   task automatic checkVector(input int i, input vec_t v);
      checkOutput($sformatf("v%0d valid", i), 32'(pe_row_valid_o), 32'(v.exp_valid));
      checkOutput($sformatf("v%0d idx", i), 32'(pe_row_idx_o), 32'(v.exp_idx));
      checkOutput($sformatf("v%0d first", i), 32'(pe_first_o), 32'(v.exp_first));
      checkOutput($sformatf("v%0d last", i), 32'(pe_last_o), 32'(v.exp_last));
      checkOutput($sformatf("v%0d busy", i), 32'(busy_o), 32'(v.exp_busy));
      checkOutput($sformatf("v%0d done", i), 32'(frame_done_o), 32'(v.exp_done));
      checkOutput($sformatf("v%0d ovf", i), 32'(overflow_o), 32'(v.exp_ovf));
      checkOutput($sformatf("v%0d perr", i), 32'(proto_err_o), 32'(v.exp_perr));
      if (v.exp_valid) begin
         checkRow($sformatf("v%0d row", i), v.exp_lane0);
      end
   endtask

   initial begin
      logic early;

      // Full frame table: 64 words back to back with ready high, one cycle
      // for the last handshake, then 8 result strobes and one quiet cycle.
      // Row r carries words 10*(r+1)+j; it completes on edge 8r+8 and is
      // accepted on edge 8r+9.
      for (int v = 1; v <= 74; v++) begin
         vec_t t;
         int   hs;
         t = '{default: '0};
         t.ready = 1'b1;
         if (v <= 64) begin
            t.load_en = 1'b1;
            t.payload = 32'(10 * ((v - 1) / 8 + 1) + (v - 1) % 8);
         end
         t.res       = (v >= 66) && (v <= 73);
         t.exp_valid = (v <= 64) && (v % 8 == 0);
         hs          = (v <= 64) ? (v - 1) / 8 : 8;
         t.exp_idx   = 3'(hs % 8);
         t.exp_first = t.exp_valid && (hs % 8 == 0);
         t.exp_last  = t.exp_valid && (hs % 8 == 7);
         t.exp_lane0 = 32'(10 * (v / 8));
         t.exp_busy  = (v >= 8) && (v < 73);
         t.exp_done  = (v == 73);
         vecs.push_back(t);
      end

      #2;
      doReset("reset0");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkVector(i + 1, vecs[i]);
      end
      pe_row_ready_i = 1'b0;
      result_valid_i = 1'b0;

      // Overflow: two rows buffered with ready low, the 17th word is dropped.
      $display("[TB] overflow sequence");
      doReset("reset1");
      for (int w = 30; w <= 46; w++) begin
         sendWord(32'(w));
         if (w == 45) checkOutput("ovf before drop", 32'(overflow_o), 0);
      end
      checkOutput("ovf after drop", 32'(overflow_o), 1);
      checkOutput("ovf row0 valid", 32'(pe_row_valid_o), 1);
      checkOutput("ovf row0 idx", 32'(pe_row_idx_o), 0);
      checkRow("ovf row0", 32'd30);
      pe_row_ready_i = 1'b1;
      tick();
      checkOutput("ovf row1 valid", 32'(pe_row_valid_o), 1);
      checkOutput("ovf row1 idx", 32'(pe_row_idx_o), 1);
      checkOutput("ovf row1 first", 32'(pe_first_o), 0);
      checkRow("ovf row1", 32'd38);
      tick();
      checkOutput("ovf drained valid", 32'(pe_row_valid_o), 0);
      checkOutput("ovf drained idx", 32'(pe_row_idx_o), 2);
      checkOutput("ovf still set", 32'(overflow_o), 1);
      pe_row_ready_i = 1'b0;
      clr_err_i      = 1'b1;
      tick();
      clr_err_i = 1'b0;
      checkOutput("ovf cleared", 32'(overflow_o), 0);

      // Load gaps: a partial row waits indefinitely.
      $display("[TB] gap sequence");
      doReset("reset2");
      early = 1'b0;
      for (int w = 30; w <= 33; w++) begin
         sendWord(32'(w));
         early |= pe_row_valid_o;
      end
      repeat (10) begin
         tick();
         early |= pe_row_valid_o;
      end
      for (int w = 34; w <= 36; w++) begin
         sendWord(32'(w));
         early |= pe_row_valid_o;
      end
      checkOutput("gap early valid", 32'(early), 0);
      sendWord(32'd37);
      checkOutput("gap valid", 32'(pe_row_valid_o), 1);
      checkRow("gap row", 32'd30);

      // Row held during drain until the frame completes.
      $display("[TB] drain hold sequence");
      doReset("reset3");
      pe_row_ready_i = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
         for (int j = 0; j < ROW_LEN; j++) sendWord(32'(10 * (r + 1) + j));
      end
      tick();
      for (int w = 90; w <= 97; w++) sendWord(32'(w));
      checkOutput("hold valid low", 32'(pe_row_valid_o), 0);
      checkOutput("hold busy", 32'(busy_o), 1);
      repeat (3) tick();
      checkOutput("hold valid still low", 32'(pe_row_valid_o), 0);
      result_valid_i = 1'b1;
      repeat (7) tick();
      checkOutput("hold 7 strobes done", 32'(frame_done_o), 0);
      checkOutput("hold 7 strobes valid", 32'(pe_row_valid_o), 0);
      pe_row_ready_i = 1'b0;
      tick();
      result_valid_i = 1'b0;
      checkOutput("hold done pulse", 32'(frame_done_o), 1);
      checkOutput("hold issued valid", 32'(pe_row_valid_o), 1);
      checkOutput("hold issued idx", 32'(pe_row_idx_o), 0);
      checkOutput("hold issued first", 32'(pe_first_o), 1);
      checkRow("hold row", 32'd90);
      tick();
      checkOutput("hold done ends", 32'(frame_done_o), 0);
      checkOutput("hold perr", 32'(proto_err_o), 0);

      // Protocol errors and mid-frame reset.
      $display("[TB] protocol and reset sequence");
      doReset("reset4");
      result_valid_i = 1'b1;
      tick();
      result_valid_i = 1'b0;
      checkOutput("perr idle strobe", 32'(proto_err_o), 1);
      result_valid_i = 1'b1;
      clr_err_i      = 1'b1;
      tick();
      result_valid_i = 1'b0;
      checkOutput("perr set beats clear", 32'(proto_err_o), 1);
      tick();
      clr_err_i = 1'b0;
      checkOutput("perr cleared", 32'(proto_err_o), 0);
      pe_row_ready_i = 1'b1;
      for (int j = 0; j < ROW_LEN; j++) sendWord(32'(10 + j));
      tick();
      checkOutput("perr run idx", 32'(pe_row_idx_o), 1);
      result_valid_i = 1'b1;
      tick();
      checkOutput("perr first strobe ok", 32'(proto_err_o), 0);
      tick();
      result_valid_i = 1'b0;
      checkOutput("perr excess strobe", 32'(proto_err_o), 1);
      for (int r = 1; r < 3; r++) begin
         for (int j = 0; j < ROW_LEN; j++) sendWord(32'(10 * (r + 1) + j));
      end
      tick();
      checkOutput("mid idx before reset", 32'(pe_row_idx_o), 3);
      for (int w = 40; w <= 43; w++) sendWord(32'(w));
      rst_n = 1'b0;
      #1;
      checkZeros("midreset");
      pe_row_ready_i = 1'b0;
      @(negedge clk_data);
      rst_n = 1'b1;
      for (int w = 50; w <= 57; w++) sendWord(32'(w));
      checkOutput("post reset valid", 32'(pe_row_valid_o), 1);
      checkOutput("post reset idx", 32'(pe_row_idx_o), 0);
      checkOutput("post reset first", 32'(pe_first_o), 1);
      checkRow("post reset row", 32'd50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
